// File: rtl/spi_eeprom_pkg.sv
// spi_eeprom_pkg: FSM states and SPI READ framing constants shared by the arbiter slice.
package spi_eeprom_pkg;
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, END} state_t;
  localparam logic [7:0] READ_OP = 8'h03;
  localparam int CMD_BITS = 8;
  localparam int ADDR_BITS = 16;
endpackage

// File: rtl/spi_eeprom_arbiter_engine.sv
// spi_shift_engine: SPI mode-0 bit engine; shifts one W-bit frame MSB-first and flags its last cycle.
module spi_shift_engine #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         run,
  input  logic         load,
  input  logic [W-1:0] tx_byte,
  input  logic         cipo,
  output logic         sck,
  output logic         copi,
  output logic         done,
  output logic [W-1:0] rx_byte
);
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);
  logic ph;
  logic [CW-1:0] cnt;
  logic [W-1:0] tx;
  assign sck = ph;
  assign copi = tx[W-1];
  assign done = run && ph && cnt == LAST;
  // copi shifts on the high->low phase step, cipo is captured on the low->high step
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ph <= 1'b0;
      cnt <= '0;
      tx <= '0;
      rx_byte <= '0;
    end else if (load) begin
      ph <= 1'b0;
      cnt <= '0;
      tx <= tx_byte;
    end else if (run) begin
      ph <= ~ph;
      if (ph) begin
        cnt <= done ? '0 : cnt + 1'b1;
        tx <= {tx[W-2:0], 1'b0};
      end else
        rx_byte <= {rx_byte[W-2:0], cipo};
    end
endmodule

// File: rtl/spi_eeprom_arbiter.sv
// spi_eeprom_arbiter: two-port round-robin arbiter issuing READ (0x03) bursts to one SPI EEPROM.
// Optional SPI_ARB_BURST_LIMIT_EN: preempt an owner after MAX_BURST bytes and resume it later.
module spi_eeprom_arbiter
  import spi_eeprom_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  output logic [1:0]        gnt,
  output logic [7:0]        rdata,
  output logic [1:0]        rvalid,
  output logic              busy,
  output logic              spi_cs_n,
  output logic              spi_sck,
  output logic              spi_copi,
  input  logic              spi_cipo
);
  state_t st, st_n;
  logic own, last, pick, bc, ec, run, done, load, deliver, pre;
  logic [7:0] tx_byte, rx_byte;
  logic [ADDR_W-1:0] nxt_addr, start;
  logic [ADDR_BITS-1:0] wa;
  assign run = st inside {CMD, ADDR, DATA};
  assign pick = &req ? ~last : req[1];
  assign wa = ADDR_BITS'(nxt_addr);
  assign deliver = st == DATA && done && req[own];
  assign gnt = run ? (own ? 2'b10 : 2'b01) : 2'b00;
  assign spi_cs_n = ~run;
  assign busy = run || st == END;
  spi_shift_engine #(.W(CMD_BITS)) u_eng (
    .clk     (clk),
    .rst     (rst),
    .run     (run),
    .load    (load),
    .tx_byte (tx_byte),
    .cipo    (spi_cipo),
    .sck     (spi_sck),
    .copi    (spi_copi),
    .done    (done),
    .rx_byte (rx_byte)
  );
`ifdef SPI_ARB_BURST_LIMIT_EN
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BLAST = BW'(MAX_BURST - 1);
  logic [BW-1:0] bcnt;
  logic [1:0] sv;
  logic [1:0][ADDR_W-1:0] sa;
  assign pre = req[~own] && bcnt == BLAST;
  assign start = sv[pick] ? sa[pick] : pick ? addr1 : addr0;
  // a preempted port's next address is parked here until its next grant
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bcnt <= '0;
      sv <= '0;
      sa <= '0;
    end else if (st == IDLE && |req) begin
      bcnt <= '0;
      sv[pick] <= 1'b0;
    end else if (deliver) begin
      bcnt <= bcnt == BLAST ? bcnt : bcnt + 1'b1;
      if (pre) begin
        sv[own] <= 1'b1;
        sa[own] <= nxt_addr + 1'b1;
      end
    end
`else
  logic unused_burst;
  assign unused_burst = ^MAX_BURST;
  assign pre = 1'b0;
  assign start = pick ? addr1 : addr0;
`endif
  always_comb begin
    st_n = st;
    load = 1'b0;
    tx_byte = 8'h00;
    case (st)
      IDLE: if (|req) begin
        st_n = CMD;
        load = 1'b1;
        tx_byte = READ_OP;
      end
      CMD: if (done) begin
        st_n = ADDR;
        load = 1'b1;
        tx_byte = wa[15:8];
      end
      ADDR: if (done) begin
        st_n = bc ? DATA : ADDR;
        load = 1'b1;
        tx_byte = bc ? 8'h00 : wa[7:0];
      end
      DATA: if (done) begin
        st_n = deliver && !pre ? DATA : END;
        load = deliver && !pre;
      end
      END: st_n = ec ? IDLE : END;
      default: st_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st <= IDLE;
      own <= 1'b0;
      last <= 1'b1;
      nxt_addr <= '0;
      bc <= 1'b0;
      ec <= 1'b0;
      rvalid <= 2'b00;
      rdata <= 8'h00;
    end else begin
      st <= st_n;
      bc <= st == ADDR && done ? ~bc : bc;
      ec <= st == END ? ~ec : 1'b0;
      rvalid <= deliver ? (own ? 2'b10 : 2'b01) : 2'b00;
      if (deliver) begin
        rdata <= rx_byte;
        nxt_addr <= nxt_addr + 1'b1;
      end
      if (st == IDLE && |req) begin
        own <= pick;
        last <= pick;
        nxt_addr <= start;
      end
    end
endmodule

// File: tb/tb_spi_eeprom_arbiter.sv
// tb_spi_eeprom_arbiter: scoreboard bench with a 1 KiB SPI EEPROM model for spi_eeprom_arbiter.
module tb_spi_eeprom_arbiter;
  typedef struct {int port; int data; int dt;} ev_t;
  logic clk = 1'b0, rst = 1'b1, cipo = 1'b0;
  logic [1:0] req = 2'b00;
  logic [9:0] addr0 = '0, addr1 = '0;
  logic [1:0] gnt, rvalid;
  logic [7:0] rdata;
  logic busy, spi_cs_n, spi_sck, spi_copi;
  int cyc = 0, total = 0, bad = 0, gc = 0, bits = 0;
  int c0, c1, c2;
  logic [1:0] pg = 2'b00;
  logic [23:0] sh = '0;
  logic [9:0] base = '0;
  logic [7:0] md;
  ev_t e;
  ev_t eq[$];
  logic [23:0] hq[$];

  spi_eeprom_arbiter #(
    .ADDR_W(10),
`ifdef SPI_ARB_BURST_LIMIT_EN
    .MAX_BURST(4)
`else
    .MAX_BURST(8)
`endif
  ) dut (
    .clk(clk), .rst(rst), .req(req), .addr0(addr0), .addr1(addr1),
    .gnt(gnt), .rdata(rdata), .rvalid(rvalid), .busy(busy),
    .spi_cs_n(spi_cs_n), .spi_sck(spi_sck), .spi_copi(spi_copi), .spi_cipo(cipo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
    total++;
    if (a !== x) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", n, a, x);
    end
  endtask

  function automatic logic [7:0] dat(input logic [9:0] a);
    return a == 10'h155 ? 8'hA5 : a == 10'h156 ? 8'h3C : a[7:0] + 8'h11;
  endfunction

  // EEPROM model: 24 header bits in on sck rise, data out on sck fall
  always @(posedge spi_sck or posedge spi_cs_n)
    if (spi_cs_n) bits = 0;
    else begin
      if (bits < 24) sh = {sh[22:0], spi_copi};
      bits++;
      if (bits == 24) begin
        base = sh[9:0];
        if (hq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL hdr_extra got=%06h", sh);
        end else chk("hdr", {8'h00, sh}, {8'h00, hq.pop_front()});
      end
    end

  always @(negedge spi_sck)
    if (!spi_cs_n && bits >= 24) begin
      md = dat(10'(int'(base) + (bits - 24) / 8));
      cipo = md[7 - ((bits - 24) % 8)];
    end

  always @(negedge clk) begin
    if (gnt != 2'b00 && pg == 2'b00) gc = cyc;
    pg = gnt;
    if (rvalid != 2'b00) begin
      if (eq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rv_extra rvalid=%b rdata=%h", rvalid, rdata);
      end else begin
        e = eq.pop_front();
        chk("rv_port", rvalid, e.port == 1 ? 2 : 1);
        chk("rv_data", rdata, e.data);
        chk("rv_lat", cyc - gc, e.dt);
      end
    end
  end

  task automatic wait_for(input logic [1:0] m, output int c);
    for (int i = 0; i < 400 && (gnt & m) == 2'b00; i++) @(negedge clk);
    if ((gnt & m) == 2'b00) begin
      total++;
      bad++;
      $display("FAIL gnt_timeout gnt=%b want=%b", gnt, m);
    end
    c = cyc;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400 && (busy || gnt != 2'b00); i++) @(negedge clk);
    if (busy) begin
      total++;
      bad++;
      $display("FAIL idle_timeout busy=%b", busy);
    end
    @(negedge clk);
  endtask

  task automatic chk_reset(input string n);
    chk({n, "_csn"}, spi_cs_n, 1);
    chk({n, "_sck"}, spi_sck, 0);
    chk({n, "_copi"}, spi_copi, 0);
    chk({n, "_gnt"}, gnt, 0);
    chk({n, "_rvalid"}, rvalid, 0);
    chk({n, "_rdata"}, rdata, 0);
    chk({n, "_busy"}, busy, 0);
    chk({n, "_state"}, dut.st, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk_reset("rst");
    // both ports request right after reset: port 0 first, drops 5 cycles into its 2nd data byte
    addr0 = 10'h010;
    addr1 = 10'h2A0;
    hq.push_back(24'h030010);
    hq.push_back(24'h0302A0);
    eq.push_back('{0, 'h21, 64});
    eq.push_back('{1, 'hB1, 64});
    rst = 1'b0;
    req = 2'b11;
    wait_for(2'b11, c0);
    chk("rr_first", gnt, 2'b01);
    repeat (69) @(negedge clk);
    req[0] = 1'b0;
    repeat (7) @(negedge clk);
    chk("tail_csn", spi_cs_n, 0);
    chk("tail_sck_lo", spi_sck, 0);
    @(negedge clk);
    chk("tail_sck_hi", spi_sck, 1);
    repeat (3) @(negedge clk);
    chk("end1_csn", spi_cs_n, 1);
    chk("end1_busy", busy, 1);
    chk("end1_gnt", gnt, 0);
    @(negedge clk);
    chk("end2_csn", spi_cs_n, 1);
    chk("end2_busy", busy, 1);
    @(negedge clk);
    chk("idle_busy", busy, 0);
    @(negedge clk);
    chk("rr_second", gnt, 2'b10);
    repeat (69) @(negedge clk);
    req = 2'b00;
    wait_idle();
    // basic two-byte read at 0x155
    addr0 = 10'h155;
    hq.push_back(24'h030155);
    eq.push_back('{0, 'hA5, 64});
    eq.push_back('{0, 'h3C, 80});
    req = 2'b01;
    wait_for(2'b11, c0);
    repeat (81) @(negedge clk);
    req = 2'b00;
    wait_idle();
    // counter wrap from 0x3FF
    addr0 = 10'h3FF;
    hq.push_back(24'h0303FF);
    eq.push_back('{0, 'h10, 64});
    eq.push_back('{0, 'h11, 80});
    req = 2'b01;
    wait_for(2'b11, c0);
    repeat (81) @(negedge clk);
    req = 2'b00;
    wait_idle();
    chk("wrap_addr", dut.nxt_addr, 10'h001);
    // port 0 served last, so port 1 wins a tie
    hq.push_back(24'h0302A0);
    eq.push_back('{1, 'hB1, 64});
    req = 2'b11;
    wait_for(2'b11, c0);
    chk("rr_tie", gnt, 2'b10);
    req[0] = 1'b0;
    repeat (69) @(negedge clk);
    req = 2'b00;
    wait_idle();
    // asynchronous reset in the middle of the address phase
    addr0 = 10'h155;
    req = 2'b01;
    wait_for(2'b11, c0);
    repeat (20) @(negedge clk);
    chk("pre_rst_state", dut.st, 2);
    #2 rst = 1'b1;
    #1 chk_reset("midrst");
    req = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    // port 1 pending while port 0 streams from 0x000
    addr0 = 10'h000;
    addr1 = 10'h100;
    hq.push_back(24'h030000);
    hq.push_back(24'h030100);
`ifdef SPI_ARB_BURST_LIMIT_EN
    hq.push_back(24'h030004);
    eq.push_back('{0, 'h11, 64});
    eq.push_back('{0, 'h12, 80});
    eq.push_back('{0, 'h13, 96});
    eq.push_back('{0, 'h14, 112});
    eq.push_back('{1, 'h11, 64});
    eq.push_back('{0, 'h15, 64});
    req = 2'b01;
    wait_for(2'b11, c0);
    req = 2'b11;
    wait_for(2'b10, c1);
    chk("burst_gap", c1 - c0, 115);
    repeat (69) @(negedge clk);
    req[1] = 1'b0;
    wait_for(2'b01, c2);
    chk("resume_gap", c2 - c1, 83);
    repeat (69) @(negedge clk);
    req = 2'b00;
    wait_idle();
`else
    eq.push_back('{0, 'h11, 64});
    eq.push_back('{0, 'h12, 80});
    eq.push_back('{0, 'h13, 96});
    eq.push_back('{0, 'h14, 112});
    eq.push_back('{0, 'h15, 128});
    eq.push_back('{1, 'h11, 64});
    req = 2'b01;
    wait_for(2'b11, c0);
    req = 2'b11;
    repeat (120) @(negedge clk);
    chk("no_preempt", gnt, 2'b01);
    repeat (13) @(negedge clk);
    req[0] = 1'b0;
    wait_for(2'b10, c1);
    chk("handover_gap", c1 - c0, 147);
    repeat (69) @(negedge clk);
    req = 2'b00;
    wait_idle();
`endif
    repeat (5) @(negedge clk);
    chk("hq_left", hq.size(), 0);
    chk("eq_left", eq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
